pattern_event_logger: RTL and testbench
=======================================

// Module: pattern_event_logger
// PURPOSE
//  Downstream consumer of the serial pattern-detector FSM's 3-bit Moore output code (det_code).
//  Timestamps every nonzero code, queues {code,timestamp} in a FWFT FIFO drained by valid/ready.
//  Keeps per-code saturating hit counters.
//  Sits between the detector and the host/status interface.
// PARAMETERS
//  DEPTH  8   FIFO entries; power of 2, >=2
//  TS_W   16  timestamp counter width
//  CNT_W  8   width of each hit counter and of drop_cnt
// PORTS
//  clk       in   1             clock, all state updates on posedge
//  rst       in   1             reset, synchronous, active-high
//  clr       in   1             sync soft clear (counters, flags, FIFO; not ts)
//  det_code  in   3             detector code; 000 = no event
//  ev_valid  out  1             FIFO head valid
//  ev_ready  in   1             consumer accepts head when ev_valid&ev_ready
//  ev_code   out  3             head code
//  ev_ts     out  TS_W          head timestamp
//  cnt1      out  CNT_W         hits of code 001
//  cnt2      out  CNT_W         hits of code 010
//  cnt3      out  CNT_W         hits of code 011
//  cnt7      out  CNT_W         hits of code 111
//  drop_cnt  out  CNT_W         events lost to full FIFO, saturating
//  ovf       out  1             sticky: any event dropped
//  bad_code  out  1             sticky: code 100/101/110 seen
//  level     out  $clog2(DEPTH)+1  FIFO occupancy
// BEHAVIOUR
//  Reset: ts, all counters, drop_cnt, level = 0.
//    ovf, bad_code, ev_valid = 0.
//    FIFO pointers = 0. ev_code/ev_ts = 0 while empty.
//  ts: free-running. +1 every cycle from 0 after rst. Wraps 2^TS_W-1 -> 0. Unaffected by clr.
//  Legal event: det_code in {001,010,011,111} sampled at posedge.
//    Matching cntN += 1, saturating at 2^CNT_W-1.
//    Push {det_code, ts as sampled that same edge}.
//  Illegal code (100,101,110): bad_code <= 1. No push. No counter change.
//  Pop: ev_valid & ev_ready at posedge. Head advances.
//  FWFT: pushed entry visible on ev_code/ev_ts with ev_valid=1 the cycle after push (latency 1).
//    Applies when the FIFO was empty.
//  Full (level==DEPTH) + push + pop same edge: both happen. level unchanged. Nothing dropped.
//  Full + push, no pop:
//    Event discarded; FIFO contents intact.
//    ovf <= 1. drop_cnt += 1 (saturating).
//    cntN still increments (counts detections, not stored events).
//  Empty + pop request: ignored (ev_valid=0). Push on empty same edge is still accepted.
//  Head stable: ev_code/ev_ts must not change while ev_valid=1 & ev_ready=0.
//  clr:
//    Next edge: FIFO emptied; counters, drop_cnt, ovf, bad_code = 0. ts keeps counting.
//    An event presented in the same cycle as clr is discarded and not counted.
//  rst dominates clr. rst mid-stream discards all queued events.
//  Pointers: $clog2(DEPTH) bits, natural wrap. level tracks push-pop exactly.
// TESTING
//  1 rst, then det_code=001 at ts=5, 010 at ts=9, ev_ready=1
//      -> events {001,5},{010,9} out in order; cnt1=1, cnt2=1.
//  2 ev_ready=0; 10 events of 011
//      -> level=8, ovf=1, drop_cnt=2, cnt3=10; drain yields first 8 ts in order.
//  3 FIFO full, push 111 and pop same edge
//      -> level stays 8, ovf stays 0, new tail ts correct.
//  4 CNT_W=8, 300 hits of 001 -> cnt1=255 holds; det_code=101 -> bad_code=1, level unchanged.
//  5 TS_W=4; event at ts=15 then 16 cycles later
//      -> second ev_ts=15 (wrapped); clr with concurrent 010
//      -> all counts 0, FIFO empty, ts continues.
//  6 rst asserted with 3 queued entries -> next cycle ev_valid=0, level=0, ts=0.

Source files
------------

// File: rtl/pattern_event_logger_if.sv
// Event stream from the logger to its consumer: FIFO head and the consumer's accept.
//   master (logger):   drives ev_valid, ev_code, ev_ts; samples ev_ready
//   slave  (consumer): samples ev_valid, ev_code, ev_ts; drives ev_ready
interface pattern_event_logger_if #(
    parameter int unsigned TS_W = 16
);
    logic            ev_valid;
    logic            ev_ready;
    logic [2:0]      ev_code;
    logic [TS_W-1:0] ev_ts;

    modport master (
        output ev_valid,
        output ev_code,
        output ev_ts,
        input  ev_ready
    );

    modport slave (
        input  ev_valid,
        input  ev_code,
        input  ev_ts,
        output ev_ready
    );
endinterface

// File: rtl/pattern_event_logger.sv
// Timestamps every nonzero pattern-detector code, queues {code, ts} in a
// first-word-fall-through FIFO drained over ev_if, and keeps per-code hit
// counters plus drop / illegal-code status.
//   clk, rst        clock; synchronous active-high reset
//   clr_i           synchronous soft clear (FIFO, counters, flags; not ts)
//   det_code_i      detector code, 000 = no event
//   ev_if           master side of the event stream (valid/ready/code/ts)
//   cnt{1,2,3,7}_o  saturating hit counters for codes 001/010/011/111
//   drop_cnt_o      saturating count of events lost to a full FIFO
//   ovf_o           sticky: an event was dropped
//   bad_code_o      sticky: code 100/101/110 was seen
//   level_o         FIFO occupancy
module pattern_event_logger #(
    parameter int unsigned DEPTH = 8,
    parameter int unsigned TS_W  = 16,
    parameter int unsigned CNT_W = 8
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     clr_i,
    input  logic [2:0]               det_code_i,
    pattern_event_logger_if.master   ev_if,
    output logic [CNT_W-1:0]         cnt1_o,
    output logic [CNT_W-1:0]         cnt2_o,
    output logic [CNT_W-1:0]         cnt3_o,
    output logic [CNT_W-1:0]         cnt7_o,
    output logic [CNT_W-1:0]         drop_cnt_o,
    output logic                     ovf_o,
    output logic                     bad_code_o,
    output logic [$clog2(DEPTH):0]   level_o
);

    localparam int unsigned PTR_W = $clog2(DEPTH);
    localparam int unsigned LVL_W = PTR_W + 1;

    typedef struct packed {
        logic [2:0]      code;
        logic [TS_W-1:0] ts;
    } entry_t;

    logic [TS_W-1:0]  ts_q;
    entry_t           mem_q   [DEPTH];
    entry_t           mem_d   [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [LVL_W-1:0] level_q, level_d;
    logic [CNT_W-1:0] cnt_q   [4];
    logic [CNT_W-1:0] cnt_d   [4];
    logic [CNT_W-1:0] drop_q, drop_d;
    logic             ovf_q, ovf_d;
    logic             bad_q, bad_d;
    logic             valid_q;
    entry_t           head_q, head_d;

    logic             legal;
    logic             illegal;
    logic             full;
    logic             pop;
    logic             push;
    logic             drop;
    logic [1:0]       cnt_idx;

    // Event classification and FIFO handshake decisions.
    assign legal   = det_code_i inside {3'b001, 3'b010, 3'b011, 3'b111};
    assign illegal = det_code_i inside {3'b100, 3'b101, 3'b110};
    assign full    = (level_q == LVL_W'(DEPTH));
    assign pop     = valid_q & ev_if.ev_ready;
    // A full FIFO still accepts a push when the head leaves on the same edge.
    assign push    = legal & (~full | pop);
    assign drop    = legal & full & ~pop;

    always_comb begin
        case (det_code_i)
            3'b001:  cnt_idx = 2'd0;
            3'b010:  cnt_idx = 2'd1;
            3'b011:  cnt_idx = 2'd2;
            default: cnt_idx = 2'd3;
        endcase
    end

    // Next-state for FIFO, counters and flags.
    always_comb begin
        mem_d    = mem_q;
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        level_d  = level_q;
        cnt_d    = cnt_q;
        drop_d   = drop_q;
        ovf_d    = ovf_q;
        bad_d    = bad_q;

        if (clr_i) begin
            wr_ptr_d = '0;
            rd_ptr_d = '0;
            level_d  = '0;
            for (int i = 0; i < 4; i++) begin
                cnt_d[i] = '0;
            end
            drop_d   = '0;
            ovf_d    = 1'b0;
            bad_d    = 1'b0;
        end else begin
            if (push) begin
                mem_d[wr_ptr_q] = '{code: det_code_i, ts: ts_q};
                wr_ptr_d        = wr_ptr_q + PTR_W'(1);
            end
            if (pop) begin
                rd_ptr_d = rd_ptr_q + PTR_W'(1);
            end
            level_d = level_q + LVL_W'(push) - LVL_W'(pop);

            // Counters track detections, including ones the FIFO had to drop.
            if (legal && (cnt_q[cnt_idx] != '1)) begin
                cnt_d[cnt_idx] = cnt_q[cnt_idx] + CNT_W'(1);
            end
            if (drop) begin
                ovf_d = 1'b1;
                if (drop_q != '1) begin
                    drop_d = drop_q + CNT_W'(1);
                end
            end
            if (illegal) begin
                bad_d = 1'b1;
            end
        end

        // Head is registered from next state so a fresh push shows one cycle later.
        head_d = (level_d != '0) ? mem_d[rd_ptr_d] : '0;
    end

    // State registers; ts is only touched by rst.
    always_ff @(posedge clk) begin
        if (rst) begin
            ts_q     <= '0;
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            level_q  <= '0;
            for (int i = 0; i < 4; i++) begin
                cnt_q[i] <= '0;
            end
            drop_q   <= '0;
            ovf_q    <= 1'b0;
            bad_q    <= 1'b0;
            valid_q  <= 1'b0;
            head_q   <= '0;
        end else begin
            ts_q     <= ts_q + TS_W'(1);
            mem_q    <= mem_d;
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            level_q  <= level_d;
            cnt_q    <= cnt_d;
            drop_q   <= drop_d;
            ovf_q    <= ovf_d;
            bad_q    <= bad_d;
            valid_q  <= (level_d != '0);
            head_q   <= head_d;
        end
    end

    assign ev_if.ev_valid = valid_q;
    assign ev_if.ev_code  = head_q.code;
    assign ev_if.ev_ts    = head_q.ts;
    assign cnt1_o         = cnt_q[0];
    assign cnt2_o         = cnt_q[1];
    assign cnt3_o         = cnt_q[2];
    assign cnt7_o         = cnt_q[3];
    assign drop_cnt_o     = drop_q;
    assign ovf_o          = ovf_q;
    assign bad_code_o     = bad_q;
    assign level_o        = level_q;

endmodule

// File: tb/tb_pattern_event_logger.sv
// Bench for pattern_event_logger: two instances (TS_W=16 and TS_W=4) share one
// stimulus stream and are compared every cycle against a queue-based model,
// plus a directed vector table and hand-written corner sequences.
module tb_pattern_event_logger;

    localparam int DEPTH   = 8;
    localparam int CNT_MAX = 255;

    bit         clk = 1'b0;
    logic       rst;
    logic       clr;
    logic [2:0] det;
    logic       rdy;

    always #5 clk = ~clk;

    pattern_event_logger_if #(.TS_W(16)) bus16 ();
    pattern_event_logger_if #(.TS_W(4))  bus4  ();

    assign bus16.ev_ready = rdy;
    assign bus4.ev_ready  = rdy;

    logic [7:0]  c1  [2];
    logic [7:0]  c2  [2];
    logic [7:0]  c3  [2];
    logic [7:0]  c7  [2];
    logic [7:0]  drp [2];
    logic        ovf [2];
    logic        bad [2];
    logic [3:0]  lvl [2];
    logic        vld [2];
    logic [2:0]  cod [2];
    logic [15:0] tsv [2];

    assign vld[0] = bus16.ev_valid;
    assign cod[0] = bus16.ev_code;
    assign tsv[0] = bus16.ev_ts;
    assign vld[1] = bus4.ev_valid;
    assign cod[1] = bus4.ev_code;
    assign tsv[1] = {12'b0, bus4.ev_ts};

    pattern_event_logger #(.DEPTH(DEPTH), .TS_W(16), .CNT_W(8)) u_dut16 (
        .clk(clk), .rst(rst), .clr_i(clr), .det_code_i(det), .ev_if(bus16.master),
        .cnt1_o(c1[0]), .cnt2_o(c2[0]), .cnt3_o(c3[0]), .cnt7_o(c7[0]),
        .drop_cnt_o(drp[0]), .ovf_o(ovf[0]), .bad_code_o(bad[0]), .level_o(lvl[0])
    );

    pattern_event_logger #(.DEPTH(DEPTH), .TS_W(4), .CNT_W(8)) u_dut4 (
        .clk(clk), .rst(rst), .clr_i(clr), .det_code_i(det), .ev_if(bus4.master),
        .cnt1_o(c1[1]), .cnt2_o(c2[1]), .cnt3_o(c3[1]), .cnt7_o(c7[1]),
        .drop_cnt_o(drp[1]), .ovf_o(ovf[1]), .bad_code_o(bad[1]), .level_o(lvl[1])
    );

    int n_chk = 0;
    int n_err = 0;

    // Reference model: a queue of stored events and plain integer counters.
    typedef struct {
        int code;
        int ts;
    } ev_t;

    ev_t mq [$];
    int  m_cnt [4];
    int  m_drop;
    bit  m_ovf;
    bit  m_bad;
    int  m_ts;

    function automatic int code_idx(input int c);
        case (c)
            1:       return 0;
            2:       return 1;
            3:       return 2;
            7:       return 3;
            default: return -1;
        endcase
    endfunction

    task automatic model_clear();
        mq.delete();
        for (int i = 0; i < 4; i++) m_cnt[i] = 0;
        m_drop = 0;
        m_ovf  = 1'b0;
        m_bad  = 1'b0;
    endtask

    task automatic model_edge();
        int cur_ts;
        int k;
        if (rst) begin
            model_clear();
            m_ts = 0;
            return;
        end
        cur_ts = m_ts;
        m_ts   = m_ts + 1;
        if (clr) begin
            model_clear();
            return;
        end
        if (mq.size() > 0 && rdy) mq.delete(0);
        k = code_idx(int'(det));
        if (k >= 0) begin
            if (m_cnt[k] < CNT_MAX) m_cnt[k]++;
            if (mq.size() < DEPTH) begin
                mq.push_back('{code: int'(det), ts: cur_ts});
            end else begin
                m_ovf = 1'b1;
                if (m_drop < CNT_MAX) m_drop++;
            end
        end else if (int'(det) >= 4) begin
            m_bad = 1'b1;
        end
    endtask

    task automatic chk(input string name, input longint act, input longint exp);
        n_chk++;
        if (act != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic compare_all();
        int  ev;
        int  ec;
        int  et;
        for (int k = 0; k < 2; k++) begin
            ev = (mq.size() > 0) ? 1 : 0;
            ec = ev ? mq[0].code : 0;
            et = ev ? (mq[0].ts & ((k == 0) ? 32'hFFFF : 32'hF)) : 0;
            chk($sformatf("ev_valid[%0d]", k), longint'(vld[k]), longint'(ev));
            chk($sformatf("ev_code[%0d]", k),  longint'(cod[k]), longint'(ec));
            chk($sformatf("ev_ts[%0d]", k),    longint'(tsv[k]), longint'(et));
            chk($sformatf("level[%0d]", k),    longint'(lvl[k]), longint'(mq.size()));
            chk($sformatf("cnt1[%0d]", k),     longint'(c1[k]),  longint'(m_cnt[0]));
            chk($sformatf("cnt2[%0d]", k),     longint'(c2[k]),  longint'(m_cnt[1]));
            chk($sformatf("cnt3[%0d]", k),     longint'(c3[k]),  longint'(m_cnt[2]));
            chk($sformatf("cnt7[%0d]", k),     longint'(c7[k]),  longint'(m_cnt[3]));
            chk($sformatf("drop_cnt[%0d]", k), longint'(drp[k]), longint'(m_drop));
            chk($sformatf("ovf[%0d]", k),      longint'(ovf[k]), longint'(m_ovf));
            chk($sformatf("bad_code[%0d]", k), longint'(bad[k]), longint'(m_bad));
        end
    endtask

    // One clock: drive inputs, let the edge happen, advance model, compare.
    task automatic cycle(input bit r, input bit c, input logic [2:0] d, input bit y);
        rst = r;
        clr = c;
        det = d;
        rdy = y;
        @(posedge clk);
        model_edge();
        #1;
        compare_all();
    endtask

    task automatic idle(input int n, input bit y);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 3'd0, y);
    endtask

    typedef struct {
        bit         clr;
        logic [2:0] det;
        bit         rdy;
        int         exp_valid;
        int         exp_code;
        int         exp_level;
    } vec_t;

    vec_t vecs [7];

    initial begin
        int tail_ts;
        int exp_ts;

        vecs[0] = '{clr: 1'b0, det: 3'd1, rdy: 1'b0, exp_valid: 1, exp_code: 1, exp_level: 1};
        vecs[1] = '{clr: 1'b0, det: 3'd4, rdy: 1'b0, exp_valid: 1, exp_code: 1, exp_level: 1};
        vecs[2] = '{clr: 1'b0, det: 3'd2, rdy: 1'b1, exp_valid: 1, exp_code: 2, exp_level: 1};
        vecs[3] = '{clr: 1'b0, det: 3'd0, rdy: 1'b1, exp_valid: 0, exp_code: 0, exp_level: 0};
        vecs[4] = '{clr: 1'b0, det: 3'd7, rdy: 1'b1, exp_valid: 1, exp_code: 7, exp_level: 1};
        vecs[5] = '{clr: 1'b0, det: 3'd3, rdy: 1'b0, exp_valid: 1, exp_code: 7, exp_level: 2};
        vecs[6] = '{clr: 1'b1, det: 3'd0, rdy: 1'b0, exp_valid: 0, exp_code: 0, exp_level: 0};

        rst = 1'b1;
        clr = 1'b0;
        det = 3'd0;
        rdy = 1'b0;
        m_ts = 0;
        model_clear();

        // Reset state.
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        chk("reset_valid", longint'(vld[0]), 0);
        chk("reset_level", longint'(lvl[0]), 0);
        chk("reset_cnt1",  longint'(c1[0]),  0);

        // Directed vector table.
        for (int i = 0; i < 7; i++) begin
            cycle(1'b0, vecs[i].clr, vecs[i].det, vecs[i].rdy);
            chk($sformatf("vec%0d_valid", i), longint'(vld[0]), longint'(vecs[i].exp_valid));
            chk($sformatf("vec%0d_code", i),  longint'(cod[0]), longint'(vecs[i].exp_code));
            chk($sformatf("vec%0d_level", i), longint'(lvl[0]), longint'(vecs[i].exp_level));
        end

        // Two events at ts=5 and ts=9 delivered in order.
        cycle(1'b1, 1'b0, 3'd0, 1'b1);
        idle(5, 1'b1);
        cycle(1'b0, 1'b0, 3'd1, 1'b1);
        chk("t1_first_ts",   longint'(tsv[0]), 5);
        chk("t1_first_code", longint'(cod[0]), 1);
        idle(3, 1'b1);
        cycle(1'b0, 1'b0, 3'd2, 1'b1);
        chk("t1_second_ts",   longint'(tsv[0]), 9);
        chk("t1_second_code", longint'(cod[0]), 2);
        chk("t1_cnt1", longint'(c1[0]), 1);
        chk("t1_cnt2", longint'(c2[0]), 1);

        // Overflow: 10 events into an undrained FIFO, then drain in order.
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        for (int i = 0; i < 10; i++) cycle(1'b0, 1'b0, 3'd3, 1'b0);
        chk("t2_level", longint'(lvl[0]), 8);
        chk("t2_ovf",   longint'(ovf[0]), 1);
        chk("t2_drop",  longint'(drp[0]), 2);
        chk("t2_cnt3",  longint'(c3[0]), 10);
        for (int i = 0; i < 8; i++) begin
            chk($sformatf("t2_drain_ts%0d", i), longint'(tsv[0]), longint'(i));
            cycle(1'b0, 1'b0, 3'd0, 1'b1);
        end
        chk("t2_empty", longint'(lvl[0]), 0);

        // Full FIFO with simultaneous push and pop.
        cycle(1'b0, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 8; i++) cycle(1'b0, 1'b0, 3'd1, 1'b0);
        tail_ts = m_ts;
        cycle(1'b0, 1'b0, 3'd7, 1'b1);
        chk("t3_level", longint'(lvl[0]), 8);
        chk("t3_ovf",   longint'(ovf[0]), 0);
        chk("t3_drop",  longint'(drp[0]), 0);
        idle(7, 1'b1);
        chk("t3_tail_code", longint'(cod[0]), 7);
        chk("t3_tail_ts",   longint'(tsv[0]), longint'(tail_ts & 32'hFFFF));
        idle(1, 1'b1);

        // Counter saturation, then an illegal code.
        cycle(1'b0, 1'b1, 3'd0, 1'b0);
        for (int i = 0; i < 300; i++) cycle(1'b0, 1'b0, 3'd1, 1'b1);
        chk("t4_cnt1_sat", longint'(c1[0]), 255);
        cycle(1'b0, 1'b0, 3'd5, 1'b0);
        chk("t4_bad",   longint'(bad[0]), 1);
        chk("t4_level", longint'(lvl[0]), 1);

        // Timestamp wrap on the 4-bit instance, then clr with a concurrent event.
        cycle(1'b0, 1'b1, 3'd0, 1'b1);
        for (int i = 0; i < 32 && (m_ts % 16) != 15; i++) cycle(1'b0, 1'b0, 3'd0, 1'b0);
        chk("t5_align", longint'(m_ts % 16), 15);
        cycle(1'b0, 1'b0, 3'd1, 1'b0);
        idle(15, 1'b0);
        cycle(1'b0, 1'b0, 3'd2, 1'b0);
        chk("t5_first_ts4", longint'(tsv[1]), 15);
        cycle(1'b0, 1'b0, 3'd0, 1'b1);
        chk("t5_wrap_ts4",   longint'(tsv[1]), 15);
        chk("t5_wrap_code4", longint'(cod[1]), 2);
        cycle(1'b0, 1'b1, 3'd2, 1'b0);
        chk("t5_clr_level", longint'(lvl[1]), 0);
        chk("t5_clr_cnt2",  longint'(c2[1]), 0);
        chk("t5_clr_valid", longint'(vld[1]), 0);
        exp_ts = m_ts;
        cycle(1'b0, 1'b0, 3'd3, 1'b0);
        chk("t5_ts_continues", longint'(tsv[0]), longint'(exp_ts & 32'hFFFF));

        // Reset with entries queued.
        cycle(1'b0, 1'b0, 3'd1, 1'b0);
        cycle(1'b0, 1'b0, 3'd2, 1'b0);
        chk("t6_level_pre", longint'(lvl[0]), 3);
        cycle(1'b1, 1'b0, 3'd0, 1'b0);
        chk("t6_valid", longint'(vld[0]), 0);
        chk("t6_level", longint'(lvl[0]), 0);
        cycle(1'b0, 1'b0, 3'd7, 1'b0);
        chk("t6_ts16", longint'(tsv[0]), 0);
        chk("t6_ts4",  longint'(tsv[1]), 0);

        // Random traffic against the model.
        for (int i = 0; i < 3000; i++) begin
            logic [2:0] d;
            bit r;
            bit c;
            d = ($urandom_range(0, 1) == 0) ? 3'd0 : 3'($urandom_range(0, 7));
            r = ($urandom_range(0, 499) == 0);
            c = ($urandom_range(0, 63) == 0);
            cycle(r, c, d, ($urandom_range(0, 2) == 0));
        end

        $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
        $finish;
    end

endmodule
